// File: rtl/lynx_ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard frame transmitter.
// Frame builder used when a FIFO byte is loaded into the shift register.
package lynx_ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } ps2_tx_state_t;

  localparam int FRAME_BITS = 11;
  localparam logic [1:0] PS2_IDLE = 2'b11;

  // {stop, odd parity, data, start}; bit 0 goes out first
  function automatic logic [FRAME_BITS-1:0] ps2_frame(
    input logic [7:0] b
  );
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO holding scancodes waiting to be framed.
// Head data is read combinationally; pop advances the read pointer.
module ps2_tx_fifo
  import lynx_ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // power-of-two depth lets the pointers wrap on overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: FIFO-fed, emits
// 11-bit frames on a registered {data, clk} pair.
module ps2_kbd_tx
  import lynx_ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 1103,
  parameter int GAP_BITS    = 4,
  parameter int DEPTH       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [1:0]             ps2,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int GAP_CYC = GAP_BITS * 2 * HALF_PERIOD;
  localparam int DW = $clog2(HALF_PERIOD);
  localparam int GW = $clog2(GAP_CYC);
  localparam logic [DW-1:0] DIV_MAX  = DW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  ps2_tx_state_t         state;
  logic [FRAME_BITS-1:0] sr;
  logic [7:0]            byte_q;
  logic [7:0]            head;
  logic [DW-1:0]         div;
  logic                  half;
  logic [3:0]            bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  full;
  logic                  empty;
  logic                  pop;

  ps2_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (din_valid),
    .pop   (pop),
    .wdata (din),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign din_ready = ~full;
  assign busy      = (state != IDLE) | ~empty;
  assign pop = ~empty & ((state == IDLE) |
               ((state == GAP) & (gap_cnt == GAP_MAX)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ps2     <= PS2_IDLE;
      sr      <= '0;
      byte_q  <= '0;
      div     <= '0;
      half    <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ps2 <= PS2_IDLE;
          if (pop) begin
            byte_q <= head;
            state  <= LOAD;
          end
        end
        LOAD: begin
          ps2     <= PS2_IDLE;
          sr      <= ps2_frame(byte_q);
          div     <= '0;
          half    <= 1'b0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          // clk high in the first half-bit, low in the second
          ps2 <= {sr[0], ~half};
          if (div == DIV_MAX) begin
            div  <= '0;
            half <= ~half;
            if (half) begin
              sr      <= {1'b0, sr[FRAME_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                gap_cnt <= '0;
                state   <= GAP;
              end
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        GAP: begin
          ps2 <= PS2_IDLE;
          if (gap_cnt == GAP_MAX) begin
            gap_cnt <= '0;
            if (pop) begin
              byte_q <= head;
              state  <= LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: decodes frames off the bus at clk falls
// and compares them with a queue of accepted bytes.
module tb_ps2_kbd_tx;

  localparam int HP        = 4;
  localparam int GB        = 2;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = 22 * HP;
  localparam int GAP_CYC   = 2 * GB * HP;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [7:0]             din = '0;
  logic                   din_valid = 1'b0;
  logic                   din_ready;
  logic [1:0]             ps2;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;

  ps2_kbd_tx #(
    .HALF_PERIOD (HP),
    .GAP_BITS    (GB),
    .DEPTH       (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ps2       (ps2),
    .busy      (busy),
    .level     (level)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0]  exp_q[$];
  int          sof_t[$];
  int          ff_t[$];
  int          eof_t[$];
  logic [1:0]  prev = 2'b11;
  logic [10:0] fr = '0;
  logic [10:0] last_fr = '0;
  int          nb = 0;
  int          falls = 0;
  bit          in_stop = 1'b0;

  // model: start 0, data LSB first, odd parity, stop 1
  task automatic check_frame(input logic [10:0] f);
    logic [7:0]  e;
    logic [10:0] m;
    chk("frame_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = '0;
      for (int i = 0; i < 8; i++) m[i+1] = e[i];
      m[9]  = ($countones(e) % 2 == 0);
      m[10] = 1'b1;
      chk("frame_bits", f, m);
    end
  endtask

  always @(negedge clock) begin
    if (nb == 0 && prev == 2'b11 && ps2 == 2'b01)
      sof_t.push_back(cyc);
    if (prev[0] && !ps2[0]) begin
      falls++;
      if (nb == 0) ff_t.push_back(cyc);
      fr[nb] = ps2[1];
      nb++;
      if (nb == 11) begin
        nb      = 0;
        in_stop = 1'b1;
        last_fr = fr;
        check_frame(fr);
      end
    end else if (in_stop && !prev[0] && ps2[0]) begin
      eof_t.push_back(cyc);
      in_stop = 1'b0;
    end
    prev = ps2;
  end

  task automatic push(input logic [7:0] b, output int t_acc);
    int k = 0;
    t_acc = -1;
    @(negedge clock);
    din       = b;
    din_valid = 1'b1;
    while (!din_ready && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (!din_ready) begin
      chk("push_timeout", k, 0);
      din_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      t_acc = cyc;
      exp_q.push_back(b);
      din_valid = 1'b0;
    end
  endtask

  task automatic wait_eofs(input int n);
    int k = 0;
    while (eof_t.size() < n && k < 6000) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (eof_t.size() < n) chk("frame_timeout", eof_t.size(), n);
  endtask

  task automatic wait_idle(output int t);
    int k = 0;
    t = -1;
    while (busy && k < 6000) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    else t = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t9, ti, base, s0, blow, k, f0;
    logic [7:0] a, b;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ps2", ps2, 2'b11);
    chk("rst_ready", din_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);

    // single byte from idle
    base = eof_t.size();
    push(8'h1C, t0);
    wait_eofs(base + 1);
    chk("lat_1c", sof_t[base] - t0, 3);
    chk("first_fall_1c", ff_t[base] - sof_t[base], HP);
    chk("len_1c", eof_t[base] - sof_t[base], FRAME_CYC);
    chk("bits_1c", last_fr, 11'b100_0011_1000);
    wait_idle(ti);
    chk("busy_fall_1c", ti - eof_t[base], GAP_CYC - 1);

    base = eof_t.size();
    push(8'h00, t0);
    wait_eofs(base + 1);
    chk("par_00", last_fr[9], 1);
    wait_idle(ti);
    base = eof_t.size();
    push(8'hFF, t0);
    wait_eofs(base + 1);
    chk("par_ff", last_fr[9], 1);
    wait_idle(ti);

    // back-to-back queued pair
    base = eof_t.size();
    s0   = sof_t.size();
    push(8'hF0, t0);
    push(8'h1C, t1);
    blow = 0;
    k    = 0;
    while (eof_t.size() < base + 2 && k < 6000) begin
      @(negedge clock);
      #1;
      if (!busy) blow++;
      k++;
    end
    chk("b2b_busy_low", blow, 0);
    chk("b2b_gap", sof_t[s0+1] - eof_t[base], GAP_CYC + 1);
    chk("b2b_sof", sof_t[s0+1] - sof_t[s0],
        FRAME_CYC + GAP_CYC + 1);
    wait_idle(ti);

    // push while the head is popped in the same cycle
    base = eof_t.size();
    a = 8'($urandom);
    b = 8'($urandom);
    push(a, t0);
    chk("lvl_one", level, 1);
    push(b, t1);
    chk("lvl_same_cycle", level, 1);
    chk("same_cycle_edge", t1 - t0, 1);
    wait_eofs(base + 2);
    wait_idle(ti);

    // random bytes with random spacing
    base = eof_t.size();
    for (int i = 0; i < 6; i++) begin
      push(8'($urandom), t0);
      repeat ($urandom_range(0, 120)) @(negedge clock);
    end
    wait_eofs(base + 6);
    wait_idle(ti);

    // fill the FIFO during a frame
    base = eof_t.size();
    s0   = sof_t.size();
    push(8'hAA, t0);
    k = 0;
    while (sof_t.size() == s0 && k < 100) begin
      @(negedge clock);
      #1;
      k++;
    end
    for (int i = 1; i <= 8; i++) push(8'(i), t1);
    chk("fill_level", level, 8);
    chk("fill_ready", din_ready, 0);
    push(8'h09, t9);
    chk("acc9_after_pop", t9 - eof_t[base], GAP_CYC);
    wait_eofs(base + 10);
    wait_idle(ti);
    chk("fill_drained", exp_q.size(), 0);

    // reset mid-frame with three bytes queued
    f0 = falls;
    push(8'h5A, t0);
    push(8'h11, t1);
    push(8'h22, t1);
    push(8'h33, t1);
    k = 0;
    while (falls < f0 + 5 && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("rst_reach_bit5", falls - f0, 5);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    nb      = 0;
    in_stop = 1'b0;
    exp_q.delete();
    f0 = falls;
    @(negedge clock);
    chk("mid_rst_ps2", ps2, 2'b11);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", din_ready, 1);
    repeat (300) @(negedge clock);
    chk("mid_rst_no_falls", falls - f0, 0);

    base = eof_t.size();
    push(8'h3C, t0);
    wait_eofs(base + 1);
    wait_idle(ti);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 keyboard frame transmitter: accepts scancode bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each as an 11-bit PS/2 frame on a 2-bit `{data, clk}` bus. The bus has the same format the lynx48 keyboard input consumes. It sits beside `hps_io` in the emu top and drives the core's `ps2` input directly. Typical uses are auto-typing, loader key injection, and bench stimulus for the core's keyboard receiver.

## Interface
Parameters:
- `HALF_PERIOD`, default 1103: `clock` cycles per PS/2 clock half-period. Legal range is ≥ 2.
- `GAP_BITS`, default 4: idle bit-times between consecutive frames. Legal range is ≥ 1.
- `DEPTH`, default 8: FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `clock`  in  1  system clock (clk_sys domain).
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  8  scancode byte to send.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  FIFO not full. A byte is accepted on any cycle where `din_valid & din_ready`.
- `ps2`  out  2  `[0]` = PS/2 clock, `[1]` = PS/2 data. Both are 1 when idle.
- `busy`  out  1  high while a frame or inter-frame gap is in progress, or the FIFO is non-empty.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Frame layout, in bit order:
  - start bit = 0
  - `din[0]`..`din[7]`, LSB first
  - odd parity = `~^din`
  - stop bit = 1
- Bit timing:
  - Each bit lasts 2×HALF_PERIOD cycles.
  - First half: clk = 1. Data is updated on the first cycle of this half.
  - Second half: clk = 0, so the falling edge is mid-bit and the receiver samples there.
- FSM states are IDLE, LOAD, SHIFT and GAP.
  - IDLE: `ps2 = 2'b11`. When the FIFO is non-empty, pop the head and go to LOAD.
  - LOAD: build the 11-bit shift register `{1, parity, din, 0}`, clear the bit counter and divider, then go to SHIFT. LOAD lasts one cycle.
  - SHIFT: drive `ps2[1]` = shift register bit 0, with clk per the half-period rule. At the end of each bit, shift right. After bit 10 completes, go to GAP.
  - GAP: `ps2 = 2'b11` for GAP_BITS×2×HALF_PERIOD cycles. Then go to LOAD if the FIFO is non-empty, otherwise to IDLE.
- Divider counts 0..HALF_PERIOD−1. The bit counter is 4 bits wide, range 0..10.
- FIFO behaviour:
  - Write when `din_valid & din_ready`. Read on the IDLE→LOAD and GAP→LOAD transitions.
  - `din_ready = ~full` (combinational from the registered count).
  - A simultaneous write and read in the same cycle is legal. `level` stays unchanged in that case.
  - Pointers wrap modulo DEPTH.
- `din_valid` while `din_ready = 0` is ignored. No byte is dropped silently except in that case.

## Timing
- Reset values:
  - `ps2 = 2'b11`, `din_ready = 1`, `busy = 0`, `level = 0`.
  - FSM = IDLE, FIFO empty, all counters 0.
- `ps2` is fully registered, so no combinational path exists from `din` to `ps2`.
- Latency with the block idle and FIFO empty, and a byte accepted at edge N:
  - `ps2[1]` goes to 0 after edge N+3 (write N, pop/IDLE→LOAD N+1, LOAD→SHIFT N+2, registered output N+3).
  - First clk falling edge: HALF_PERIOD cycles after that.
- Frame length is 22×HALF_PERIOD cycles.
- Start-of-frame to start-of-frame for back-to-back queued bytes is (22 + 2×GAP_BITS)×HALF_PERIOD + 1 cycles (the +1 is the LOAD cycle).
- `busy` falls on the cycle the FSM enters IDLE with the FIFO empty.
- Reset mid-frame:
  - On the next edge, `ps2` returns to 11 and the FIFO is flushed.
  - The truncated frame is not resumed.
- Full FIFO: `din_ready` falls the cycle after the DEPTH-th write. It rises the cycle after the next pop.

## Structure
- Package `lynx_ps2_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} ps2_tx_state_t`
  - `localparam FRAME_BITS = 11`
  - `localparam logic [1:0] PS2_IDLE = 2'b11`
- Sub-module `ps2_tx_fifo` #(`DEPTH`, `WIDTH=8`) is a synchronous FIFO with `push`, `pop`, `full`, `empty` and `level`, on the same `clock`/`reset`.
- The top file contains only the FSM, divider, shift register and output registers.

## Test plan
Bench settings: HALF_PERIOD = 4, GAP_BITS = 2.
- Send 0x1C from idle:
  - `ps2[1]` sampled at clk falling edges = 0, 0,0,1,1,1,0,0,0, 0, 1 (start, data LSB first, parity, stop).
  - First data low after edge N+3. Frame length 88 cycles.
- Send 0x00: the parity bit samples as 1. Send 0xFF: the parity bit samples as 1.
- Back-to-back 0xF0 then 0x1C:
  - Both frames are correct.
  - The idle gap between the stop bit's clk rise and the next start bit is exactly 16 cycles plus the 1 LOAD cycle.
  - `busy` stays high throughout.
- Hold `din_valid` with incrementing bytes 0x01..0x09 during one frame:
  - `level` reaches 8 and `din_ready` drops.
  - 0x09 is not accepted until a pop.
  - The sequence 0x01..0x09 is transmitted in order.
- Assert `reset` for 1 cycle at bit 5 of a frame with 3 bytes queued:
  - Next cycle: `ps2 = 11`, `level = 0`, `busy = 0`, `din_ready = 1`.
  - No further falling edges occur.
- Push and pop in the same cycle with `level` = 1: `level` stays 1 and the FIFO order is preserved.
